// File: rtl/iso_transform_pipe.sv
`default_nettype none
// ============================================================================
// Module : iso_transform_pipe
// Brief  : Pipelined GF(2) matrix-vector basis transform with two loadable matrices
// Rev    : 1.0
// ============================================================================
module iso_transform_pipe #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mat_wr,
  input  logic                     mat_sel,
  input  logic [$clog2(WIDTH)-1:0] mat_row,
  input  logic [WIDTH-1:0]         mat_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_dir,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic                     out_dir
);

  localparam int C_DW = LANES * WIDTH;

  // Row j is stored in mat_data packing: bit (WIDTH-1-k) holds M[j][k].
  typedef logic [WIDTH-1:0][WIDTH-1:0] mat_t;

  function automatic mat_t ident_mat();
    mat_t m;
    m = '0;
    for (int j = 0; j < WIDTH; j++) m[j][WIDTH-1-j] = 1'b1;
    return m;
  endfunction

  localparam mat_t C_IDENT = ident_mat();

  mat_t r_fwd;
  mat_t r_inv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd <= C_IDENT;
      r_inv <= C_IDENT;
    end else if (mat_wr && (32'(mat_row) < WIDTH)) begin
      if (mat_sel) r_inv[mat_row] <= mat_data;
      else         r_fwd[mat_row] <= mat_data;
    end
  end

  // Output is the XOR of the rows selected by the set input bits (MSB = row 0).
  mat_t            w_mat;
  logic [C_DW-1:0] w_xf;

  always_comb begin
    w_mat = in_dir ? r_inv : r_fwd;
    w_xf  = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (in_data[i*WIDTH + WIDTH-1-j]) w_xf[i*WIDTH +: WIDTH] ^= w_mat[j];
      end
    end
  end

  logic            r_v1;
  logic            r_dir1;
  logic [C_DW-1:0] r_d1;
  logic            w_adv1;
  logic            w_nxt_adv;

  assign w_adv1   = !r_v1 || w_nxt_adv;
  assign in_ready = w_adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_dir1 <= 1'b0;
      r_d1   <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_d1   <= w_xf;
        r_dir1 <= in_dir;
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_one_stage
      assign w_nxt_adv = out_ready;
      assign out_valid = r_v1;
      assign out_data  = r_d1;
      assign out_dir   = r_dir1;
    end else if (STAGES == 2) begin : g_two_stage
      logic            r_v2;
      logic            r_dir2;
      logic [C_DW-1:0] r_d2;

      assign w_nxt_adv = !r_v2 || out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2   <= 1'b0;
          r_dir2 <= 1'b0;
          r_d2   <= '0;
        end else if (w_nxt_adv) begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_d2   <= r_d1;
            r_dir2 <= r_dir1;
          end
        end
      end

      assign out_valid = r_v2;
      assign out_data  = r_d2;
      assign out_dir   = r_dir2;
    end else begin : g_bad_stages
      $error("iso_transform_pipe: STAGES must be 1 or 2");
    end
  endgenerate

endmodule
`default_nettype wire
